aux_interface: RTL and testbench



---
 rtl/aux_interface.sv | 141 ++++++++++++++
 tb/tb_aux_interface.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/aux_interface.sv
// aux_interface: auxiliary input conditioning for the APB GPIO core.
// Brings the asynchronous aux_in bus into sys_clk through a SYNC_STAGES-deep
// synchronizer and presents it as aux_i. Registered per-bit rise/fall pulses
// and a bus-wide change pulse are derived from aux_i.
// Optional bus-wide glitch filter: define AUX_GLITCH_FILTER_EN.
module aux_interface #(
    parameter int unsigned DW          = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [DW-1:0] aux_in,
    output logic [DW-1:0] aux_i,
    output logic [DW-1:0] aux_rise,
    output logic [DW-1:0] aux_fall,
    output logic          aux_chg
);

    // Elaboration-time parameter range checks
    if (DW < 1 || DW > 32) begin : g_bad_dw
        $error("aux_interface: DW must be in 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("aux_interface: SYNC_STAGES must be in 2..4");
    end
    if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter
        $error("aux_interface: FILTER_LEN must be in 2..15");
    end

    // ------------------------------------------------------------------
    // Synchronizer: stage 0 samples aux_in, stage k samples stage k-1
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][DW-1:0] sync_q;
    logic [SYNC_STAGES-1:0][DW-1:0] sync_d;
    logic [DW-1:0]                  sync_out;

    // Shift the chain by one stage per cycle
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], aux_in};
    end

    // Synchronizer flops, flushed to zero on reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Value presented on aux_i (raw or filtered)
    // ------------------------------------------------------------------
    logic [DW-1:0] aux_val;

`ifdef AUX_GLITCH_FILTER_EN
    localparam logic [3:0] CNT_MAX  = 4'(FILTER_LEN);
    localparam logic [3:0] CNT_LOAD = 4'(FILTER_LEN - 1);

    logic [DW-1:0] sync_prev_q, sync_prev_d;
    logic [3:0]    stab_cnt_q,  stab_cnt_d;
    logic [DW-1:0] filt_q,      filt_d;
    logic          sync_same;

    // Stability counter and filtered-value update.
    // The load fires on the cycle the counter steps into FILTER_LEN-1, so a
    // change on sync_out reaches aux_i exactly FILTER_LEN cycles later.
    always_comb begin
        sync_prev_d = sync_out;
        stab_cnt_d  = stab_cnt_q;
        filt_d      = filt_q;
        sync_same   = (sync_out == sync_prev_q);
        if (!sync_same) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != CNT_MAX) begin
            stab_cnt_d = stab_cnt_q + 4'd1;
        end
        if (sync_same && (stab_cnt_d == CNT_LOAD)) begin
            filt_d = sync_out;
        end
    end

    // Filter state registers, cleared on reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_prev_q <= '0;
            stab_cnt_q  <= '0;
            filt_q      <= '0;
        end else begin
            sync_prev_q <= sync_prev_d;
            stab_cnt_q  <= stab_cnt_d;
            filt_q      <= filt_d;
        end
    end

    assign aux_val = filt_q;
`else
    assign aux_val = sync_out;
`endif

    assign aux_i = aux_val;

    // ------------------------------------------------------------------
    // Edge detection on aux_i, all outputs registered
    // ------------------------------------------------------------------
    logic [DW-1:0] aux_prev_q, aux_prev_d;
    logic [DW-1:0] aux_rise_q, aux_rise_d;
    logic [DW-1:0] aux_fall_q, aux_fall_d;
    logic          aux_chg_q,  aux_chg_d;

    // Compare current aux_i against its previous-cycle value
    always_comb begin
        aux_prev_d = aux_val;
        aux_rise_d = aux_val & ~aux_prev_q;
        aux_fall_d = ~aux_val & aux_prev_q;
        aux_chg_d  = |(aux_val ^ aux_prev_q);
    end

    // Edge registers, reset has priority
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            aux_prev_q <= '0;
            aux_rise_q <= '0;
            aux_fall_q <= '0;
            aux_chg_q  <= 1'b0;
        end else begin
            aux_prev_q <= aux_prev_d;
            aux_rise_q <= aux_rise_d;
            aux_fall_q <= aux_fall_d;
            aux_chg_q  <= aux_chg_d;
        end
    end

    assign aux_rise = aux_rise_q;
    assign aux_fall = aux_fall_q;
    assign aux_chg  = aux_chg_q;

endmodule

// File: tb/tb_aux_interface.sv
// Self-checking bench for aux_interface.
// Default build: scoreboard of expected aux_i values queued at drive time.
// With AUX_GLITCH_FILTER_EN defined: directed glitch-filter checks.
module tb_aux_interface;

    localparam int unsigned SYNC = 2;
    localparam int unsigned FLEN = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [31:0] aux_in  = '0;
    logic [31:0] aux_i;
    logic [31:0] aux_rise;
    logic [31:0] aux_fall;
    logic        aux_chg;

    int checks   = 0;
    int failures = 0;

    aux_interface #(
        .DW         (32),
        .SYNC_STAGES(SYNC),
        .FILTER_LEN (FLEN)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .aux_in  (aux_in),
        .aux_i   (aux_i),
        .aux_rise(aux_rise),
        .aux_fall(aux_fall),
        .aux_chg (aux_chg)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

`ifndef AUX_GLITCH_FILTER_EN
    // Scoreboard state: queued aux_i values and the two most recent
    // expected aux_i values (for pulse prediction).
    logic [31:0] exp_q[$];
    logic [31:0] last_ai  = '0;
    logic [31:0] last2_ai = '0;
    logic [31:0] e_ai, e_rise, e_fall;
    logic        e_chg;
`endif

    // Drive one cycle of stimulus, then sample #1 after the rising edge
    task automatic step(input logic [31:0] v, input logic rst);
        @(negedge sys_clk);
        aux_in  = v;
        sys_rst = rst;
`ifndef AUX_GLITCH_FILTER_EN
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < int'(SYNC); i++) exp_q.push_back('0);
        end else begin
            exp_q.push_back(v);
        end
`endif
        @(posedge sys_clk);
        #1;
`ifndef AUX_GLITCH_FILTER_EN
        e_ai = exp_q.pop_front();
        if (rst) begin
            e_rise   = '0;
            e_fall   = '0;
            e_chg    = 1'b0;
            last2_ai = '0;
        end else begin
            e_rise   = last_ai & ~last2_ai;
            e_fall   = ~last_ai & last2_ai;
            e_chg    = |(last_ai ^ last2_ai);
            last2_ai = last_ai;
        end
        last_ai = e_ai;
        chk("sb_aux_i", aux_i, e_ai);
        chk("sb_rise", aux_rise, e_rise);
        chk("sb_fall", aux_fall, e_fall);
        chk("sb_chg", {31'd0, aux_chg}, {31'd0, e_chg});
`endif
    endtask

    initial begin
        int unsigned hold;
        logic [31:0] v;
        logic        r;

`ifndef AUX_GLITCH_FILTER_EN
        for (int i = 0; i < int'(SYNC) - 1; i++) exp_q.push_back('0);

        // Reset state
        step(32'h0, 1'b1);
        chk("rst_aux_i", aux_i, 32'h0);
        chk("rst_rise", aux_rise, 32'h0);
        chk("rst_fall", aux_fall, 32'h0);
        chk("rst_chg", {31'd0, aux_chg}, 32'd0);

        // Latency and toggle sequence
        step(32'hA5A5A5A5, 1'b0);
        chk("lat_not_yet", aux_i, 32'h0);
        step(32'h5A5A5A5A, 1'b0);
        chk("lat_a5", aux_i, 32'hA5A5A5A5);
        step(32'hFFFFFFFF, 1'b0);
        chk("tog_5a_ai", aux_i, 32'h5A5A5A5A);
        chk("lat_rise_a5", aux_rise, 32'hA5A5A5A5);
        chk("lat_chg", {31'd0, aux_chg}, 32'd1);
        step(32'h00000000, 1'b0);
        chk("tog_ff_ai", aux_i, 32'hFFFFFFFF);
        chk("tog_5a_rise", aux_rise, 32'h5A5A5A5A);
        chk("tog_5a_fall", aux_fall, 32'hA5A5A5A5);
        step(32'h00000000, 1'b0);
        chk("tog_00_ai", aux_i, 32'h0);
        chk("tog_ff_rise", aux_rise, 32'hA5A5A5A5);
        chk("tog_ff_fall", aux_fall, 32'h0);
        step(32'h00000000, 1'b0);
        chk("tog_00_fall", aux_fall, 32'hFFFFFFFF);
        chk("tog_00_rise", aux_rise, 32'h0);
        step(32'h00000000, 1'b0);
        chk("tog_quiet_chg", {31'd0, aux_chg}, 32'd0);

        // Mid-run reset with a steady all-ones input
        repeat (5) step(32'hFFFFFFFF, 1'b0);
        chk("pre_rst_ai", aux_i, 32'hFFFFFFFF);
        step(32'hFFFFFFFF, 1'b1);
        chk("mid_rst_ai", aux_i, 32'h0);
        chk("mid_rst_rise", aux_rise, 32'h0);
        chk("mid_rst_fall", aux_fall, 32'h0);
        step(32'hFFFFFFFF, 1'b0);
        chk("post_rst1_ai", aux_i, 32'h0);
        chk("post_rst1_fall", aux_fall, 32'h0);
        step(32'hFFFFFFFF, 1'b0);
        chk("post_rst2_ai", aux_i, 32'hFFFFFFFF);
        step(32'hFFFFFFFF, 1'b0);
        chk("post_rst_rise", aux_rise, 32'hFFFFFFFF);
        step(32'hFFFFFFFF, 1'b0);
        chk("post_rst_rise_once", aux_rise, 32'h0);

        // Steady input
        repeat (10) step(32'h12345678, 1'b0);
        chk("steady_ai", aux_i, 32'h12345678);
        chk("steady_rise", aux_rise, 32'h0);
        chk("steady_fall", aux_fall, 32'h0);
        chk("steady_chg", {31'd0, aux_chg}, 32'd0);

        // Random values with random hold lengths and occasional resets
        for (int i = 0; i < 40; i++) begin
            v    = $urandom;
            hold = $urandom_range(1, 3);
            r    = ($urandom_range(0, 9) == 0);
            step(v, r);
            for (int unsigned h = 1; h < hold; h++) step(v, 1'b0);
        end
        repeat (4) step(32'h0, 1'b0);
`else
        // Glitch filter: reset, settle at zero
        step(32'h0, 1'b1);
        chk("f_rst_ai", aux_i, 32'h0);
        repeat (8) step(32'h0, 1'b0);

        // Single-cycle pulse must never reach aux_i
        step(32'h1, 1'b0);
        chk("f_pulse_ai0", aux_i, 32'h0);
        for (int k = 0; k < 10; k++) begin
            step(32'h0, 1'b0);
            chk("f_pulse_ai", aux_i, 32'h0);
        end

        // Pulse of FILTER_LEN-1 cycles is also rejected
        repeat (FLEN - 1) step(32'h1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(32'h0, 1'b0);
            chk("f_short_ai", aux_i, 32'h0);
        end

        // Held input appears at cycle SYNC_STAGES+FILTER_LEN
        for (int k = 1; k <= 8; k++) begin
            step(32'h1, 1'b0);
            chk("f_hold_ai", aux_i, (k >= int'(SYNC + FLEN)) ? 32'h1 : 32'h0);
            if (k == int'(SYNC + FLEN) + 1) chk("f_hold_rise", aux_rise, 32'h1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
